// File: rtl/alu_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_pkg
//  Purpose  : Shared definitions for the EX-stage ALU control unit.
//             Holds the ALUOp, Funct, ALU operation and result-select codes,
//             the MULTU control-bit positions, the multiplier sequencer
//             state type and a helper that maps a state to its control word.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

  // ALUOp field driven by the main control unit
  localparam logic [1:0] ALUOP_MEM    = 2'b00;  // load/store address add
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branch compare subtract
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // decode on Funct
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;  // reserved, treated as add

  // R-type function field codes
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  // ALU operation codes
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // Result multiplexer select
  typedef enum logic [1:0] {
    SEL_ALU   = 2'b00,
    SEL_SHIFT = 2'b01,
    SEL_HI    = 2'b10,
    SEL_LO    = 2'b11
  } sel_e;

  // Bit positions inside the 6-bit MULTU control word
  localparam int MOP_BUSY  = 5;
  localparam int MOP_INIT  = 4;
  localparam int MOP_ADDEN = 3;
  localparam int MOP_SHIFT = 2;
  localparam int MOP_WRHL  = 1;
  localparam int MOP_DONE  = 0;

  // Default number of shift-add iterations (operand width)
  localparam int MULT_STEPS_DEFAULT = 32;

  // Multiplier sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    INIT = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } mseq_state_e;

  // Control word presented while the sequencer sits in a given state.
  function automatic logic [5:0] mop_encode(input mseq_state_e s);
    logic [5:0] w;
    w = '0;
    case (s)
      INIT: begin
        w[MOP_BUSY] = 1'b1;
        w[MOP_INIT] = 1'b1;
      end
      RUN: begin
        // AddEn is only an enable; the datapath gates it with the multiplier LSB
        w[MOP_BUSY]  = 1'b1;
        w[MOP_ADDEN] = 1'b1;
        w[MOP_SHIFT] = 1'b1;
      end
      DONE: begin
        w[MOP_BUSY] = 1'b1;
        w[MOP_WRHL] = 1'b1;
        w[MOP_DONE] = 1'b1;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_control_unit_if
//  Purpose  : Bundle of the decode inputs and control outputs of the ALU
//             control unit.
//  Signals  : ALUOp          [1:0]  main-control operation class
//             Funct          [5:0]  R-type function field
//             Sel            [1:0]  result mux select
//             ALUOperation   [2:0]  ALU operation code
//             MULTUOperation [5:0]  multiplier control word
//  Modports : master - pipeline side (drives ALUOp/Funct)
//             slave  - control unit side (drives the control outputs)
//  Revision : 1.0  initial release
// ============================================================================
interface alu_control_unit_if;

  logic [1:0] ALUOp;
  logic [5:0] Funct;
  logic [1:0] Sel;
  logic [2:0] ALUOperation;
  logic [5:0] MULTUOperation;

  modport master (
    output ALUOp,
    output Funct,
    input  Sel,
    input  ALUOperation,
    input  MULTUOperation
  );

  modport slave (
    input  ALUOp,
    input  Funct,
    output Sel,
    output ALUOperation,
    output MULTUOperation
  );

endinterface
`default_nettype wire

// File: rtl/alu_control_unit_multu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : multu_sequencer
//  Purpose  : Clocked controller for the shift-add unsigned multiplier.
//             A rising edge on req while idle launches one INIT cycle,
//             MULT_STEPS RUN cycles and one DONE cycle, then returns idle.
//  Ports    : Clk             in   1  system clock
//             Rst             in   1  synchronous active-high reset
//             req             in   1  MULTU decoded in EX (level)
//             MULTUOperation  out  6  registered control word of current state
//  Revision : 1.0  initial release
// ============================================================================
module multu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MULT_STEPS = MULT_STEPS_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       req,
  output logic [5:0] MULTUOperation
);

  localparam int CNT_W = (MULT_STEPS > 1) ? $clog2(MULT_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mseq_state_e      state;
  mseq_state_e      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             req_q;
  logic             start;
  logic [5:0]       mop_q;

  // Edge detect: a request that is simply held high never retriggers.
  assign start = req & ~req_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= 1'b0;
      mop_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      req_q <= req;
      // Registered alongside the state so the output always matches it
      mop_q <= mop_encode(state_next);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        // Requests arriving in any other state are dropped, not queued
        if (start) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end
      INIT: begin
        state_next = RUN;
        cnt_next   = '0;
      end
      RUN: begin
        cnt_next = cnt + CNT_ONE;
        if (cnt == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign MULTUOperation = mop_q;

endmodule
`default_nettype wire

// File: rtl/alu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_control_unit
//  Purpose  : EX-stage control decoder. Combinationally maps ALUOp/Funct to
//             the ALU operation and the result-source select, and drives the
//             MULTU sequencer that controls the shift-add multiplier.
//  Ports    : Clk   in      1  system clock
//             Rst   in      1  synchronous active-high reset
//             bus   slave      ALUOp/Funct in; Sel/ALUOperation/
//                              MULTUOperation out
//  Revision : 1.0  initial release
// ============================================================================
module alu_control_unit
  import alu_ctrl_pkg::*;
#(
  parameter int MULT_STEPS = MULT_STEPS_DEFAULT
) (
  input  logic               Clk,
  input  logic               Rst,
  alu_control_unit_if.slave  bus
);

  alu_op_e    alu_operation;
  sel_e       sel;
  logic       multu_req;
  logic [5:0] multu_operation;

  // Pure decode: independent of Rst, so it tracks the inputs even in reset.
  always_comb begin
    alu_operation = ALU_ADD;
    sel           = SEL_ALU;
    case (bus.ALUOp)
      ALUOP_BRANCH: alu_operation = ALU_SUB;
      ALUOP_RTYPE: begin
        case (bus.Funct)
          FUNCT_ADD:   alu_operation = ALU_ADD;
          FUNCT_SUB:   alu_operation = ALU_SUB;
          FUNCT_AND:   alu_operation = ALU_AND;
          FUNCT_OR:    alu_operation = ALU_OR;
          FUNCT_SLT:   alu_operation = ALU_SLT;
          FUNCT_SRL:   sel           = SEL_SHIFT;
          FUNCT_MFHI:  sel           = SEL_HI;
          FUNCT_MFLO:  sel           = SEL_LO;
          // MULTU leaves the ALU path idle; the result lands in HI/LO later
          FUNCT_MULTU: alu_operation = ALU_ADD;
          default:     alu_operation = ALU_ADD;
        endcase
      end
      // Load/store and the reserved code both fall back to an add
      ALUOP_MEM,
      ALUOP_RSVD:  alu_operation = ALU_ADD;
      default:     alu_operation = ALU_ADD;
    endcase
  end

  assign multu_req = (bus.ALUOp == ALUOP_RTYPE) && (bus.Funct == FUNCT_MULTU);

  multu_sequencer #(
    .MULT_STEPS (MULT_STEPS)
  ) u_multu_sequencer (
    .Clk            (Clk),
    .Rst            (Rst),
    .req            (multu_req),
    .MULTUOperation (multu_operation)
  );

  assign bus.ALUOperation   = alu_operation;
  assign bus.Sel            = sel;
  assign bus.MULTUOperation = multu_operation;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_control_unit
//  Purpose  : Self-checking bench for alu_control_unit. A behavioural model
//             tracks the multiplier progress as "cycles since start" and the
//             decode as a lookup of the opcode table; a compare process
//             checks every cycle, and directed steps pin literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_control_unit;

  localparam int STEPS = 32;

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [2:0] alu;
    logic [1:0] sel;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_control_unit_if bus ();

  alu_control_unit #(.MULT_STEPS(STEPS)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, wanted %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // phase = cycles elapsed since the sequence started; -1 means idle.
  function automatic logic [5:0] exp_mult(input int p);
    if (p == 0)                    return 6'b110000;
    if (p >= 1 && p <= STEPS)      return 6'b101100;
    if (p == STEPS + 1)            return 6'b100011;
    return 6'b000000;
  endfunction

  function automatic logic [4:0] exp_dec(input logic [1:0] op, input logic [5:0] f);
    logic [2:0] a;
    logic [1:0] s;
    a = 3'b010;
    s = 2'b00;
    if (op == 2'b01) a = 3'b110;
    else if (op == 2'b10) begin
      case (f)
        6'b100010: a = 3'b110;
        6'b100100: a = 3'b000;
        6'b100101: a = 3'b001;
        6'b101010: a = 3'b111;
        6'b000010: s = 2'b01;
        6'b010000: s = 2'b10;
        6'b010010: s = 2'b11;
        default:   a = 3'b010;
      endcase
    end
    return {s, a};
  endfunction

  // Single compare process: checks at negedge, advances model at posedge.
  initial begin
    int   phase;
    logic prev_req;
    logic req_now;
    logic [4:0] d;
    phase    = -1;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      d = exp_dec(bus.ALUOp, bus.Funct);
      chk("model_multu", bus.MULTUOperation, exp_mult(phase));
      chk("model_aluop", bus.ALUOperation, d[2:0]);
      chk("model_sel",   bus.Sel,          d[4:3]);
      @(posedge clk);
      req_now = (bus.ALUOp == 2'b10) && (bus.Funct == 6'b011001);
      if (rst) begin
        phase    = -1;
        prev_req = 1'b0;
      end else begin
        if (phase >= 0) phase = (phase == STEPS + 1) ? -1 : phase + 1;
        else if (req_now && !prev_req) phase = 0;
        prev_req = req_now;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  vec_t vecs [12];

  task automatic run_table();
    for (int i = 0; i < 12; i++) begin
      bus.ALUOp = vecs[i].op;
      bus.Funct = vecs[i].f;
      #1;
      chk("dec_aluop", bus.ALUOperation, vecs[i].alu);
      chk("dec_sel",   bus.Sel,          vecs[i].sel);
      tick(1);
    end
  endtask

  initial begin
    int n_init, n_run, n_done, n_other;
    logic [5:0] last;

    vecs = '{
      '{2'b00, 6'b000000, 3'b010, 2'b00},
      '{2'b01, 6'b000000, 3'b110, 2'b00},
      '{2'b11, 6'b101010, 3'b010, 2'b00},
      '{2'b10, 6'b100000, 3'b010, 2'b00},
      '{2'b10, 6'b100010, 3'b110, 2'b00},
      '{2'b10, 6'b100100, 3'b000, 2'b00},
      '{2'b10, 6'b100101, 3'b001, 2'b00},
      '{2'b10, 6'b101010, 3'b111, 2'b00},
      '{2'b10, 6'b000010, 3'b010, 2'b01},
      '{2'b10, 6'b010000, 3'b010, 2'b10},
      '{2'b10, 6'b010010, 3'b010, 2'b11},
      '{2'b10, 6'b111111, 3'b010, 2'b00}
    };

    bus.ALUOp = 2'b00;
    bus.Funct = 6'b000000;
    rst = 1'b1;
    tick(3);
    #1;
    chk("reset_multu", bus.MULTUOperation, 6'b000000);
    chk("reset_aluop", bus.ALUOperation, 3'b010);
    chk("reset_sel",   bus.Sel,          2'b00);
    rst = 1'b0;
    tick(1);

    run_table();

    // MULTU held for 40 cycles: one INIT, 32 RUN, one DONE, no restart
    bus.ALUOp = 2'b10;
    bus.Funct = 6'b011001;
    n_init = 0; n_run = 0; n_done = 0; n_other = 0;
    last = '0;
    repeat (40) begin
      @(negedge clk);
      last = bus.MULTUOperation;
      case (last)
        6'b110000: n_init++;
        6'b101100: n_run++;
        6'b100011: n_done++;
        6'b000000: ;
        default:   n_other++;
      endcase
    end
    chk("hold_init_cycles", 8'(n_init), 8'd1);
    chk("hold_run_cycles",  8'(n_run),  8'd32);
    chk("hold_done_cycles", 8'(n_done), 8'd1);
    chk("hold_bad_words",   8'(n_other), 8'd0);
    chk("hold_end_idle",    last, 6'b000000);
    chk("multu_aluop",      bus.ALUOperation, 3'b010);
    chk("multu_sel",        bus.Sel, 2'b00);

    // New request, then a re-request during RUN must be ignored
    tick(1);
    bus.Funct = 6'b000000;
    tick(1);
    bus.Funct = 6'b011001;
    tick(1);
    #1 chk("restart_init", bus.MULTUOperation, 6'b110000);
    tick(1);
    #1 chk("restart_run", bus.MULTUOperation, 6'b101100);
    bus.Funct = 6'b000000;
    tick(1);
    bus.Funct = 6'b011001;
    tick(1);
    #1 chk("rereq_in_run_ignored", bus.MULTUOperation, 6'b101100);
    tick(40);
    #1 chk("back_to_idle", bus.MULTUOperation, 6'b000000);

    // Drop and reassert after idle: fresh INIT
    bus.Funct = 6'b000000;
    tick(1);
    bus.Funct = 6'b011001;
    tick(1);
    #1 chk("new_init_after_idle", bus.MULTUOperation, 6'b110000);
    tick(1);
    tick(10);
    #1 chk("run_step10", bus.MULTUOperation, 6'b101100);

    // One-cycle reset mid-RUN; decode keeps following the inputs
    rst = 1'b1;
    #1;
    chk("rst_aluop", bus.ALUOperation, 3'b010);
    chk("rst_sel",   bus.Sel,          2'b00);
    tick(1);
    #1 chk("rst_midrun_multu", bus.MULTUOperation, 6'b000000);
    rst = 1'b0;
    // Edge detector was cleared, so the still-high request starts again
    tick(1);
    #1 chk("post_rst_init", bus.MULTUOperation, 6'b110000);
    bus.Funct = 6'b000000;
    tick(36);
    #1 chk("final_idle", bus.MULTUOperation, 6'b000000);

    run_table();
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
